// File: rtl/sp_ram_rd_ctrl.sv
// rtl/sp_ram_rd_ctrl.sv - burst read engine for sp_ram with latency tracking and credit-limited skid FIFO
//
// Purpose: accepts a start/base/len command, issues sequential RAM reads, tracks the
// fixed RAM read latency and streams the returned words to a valid/ready sink.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start, base, len      command strobe (taken only while idle), first address, word count
//   busy, done            command in progress, 1-cycle completion pulse
//   ram_clrrdy            RAM clear finished; reads held off while 0
//   ram_we, ram_addr      RAM write enable (always 0), read address
//   ram_dout              RAM read data, valid G_RDLAT cycles after ram_addr
//   out_vld/out_rdy       sink handshake
//   out_dat/out_last      sink word and end-of-burst marker
module sp_ram_rd_ctrl #(
    parameter int G_ADDR   = 10,
    parameter int G_WIDTH  = 16,
    parameter int G_RDLAT  = 1,
    parameter int G_FDEPTH = G_RDLAT + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [G_ADDR-1:0]  base,
    input  logic [G_ADDR:0]    len,
    output logic               busy,
    output logic               done,
    input  logic               ram_clrrdy,
    output logic               ram_we,
    output logic [G_ADDR-1:0]  ram_addr,
    input  logic [G_WIDTH-1:0] ram_dout,
    output logic               out_vld,
    input  logic               out_rdy,
    output logic [G_WIDTH-1:0] out_dat,
    output logic               out_last
);
    localparam int PW = (G_FDEPTH > 1) ? $clog2(G_FDEPTH) : 1;
    localparam int CW = $clog2(G_FDEPTH + 1);
    localparam int OW = CW + 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ISSUE, S_DRAIN} state_t;

    state_t             state_q, state_d;
    logic [G_ADDR-1:0]  cur_addr_q, cur_addr_d;
    logic [G_ADDR:0]    remain_q, remain_d;
    logic [G_RDLAT-1:0] vld_sr_q, vld_sr_d;
    logic [G_RDLAT-1:0] last_sr_q, last_sr_d;
    logic [G_WIDTH-1:0] fifo_dat_q [G_FDEPTH];
    logic [G_WIDTH-1:0] fifo_dat_d [G_FDEPTH];
    logic               fifo_last_q [G_FDEPTH];
    logic               fifo_last_d [G_FDEPTH];
    logic [PW-1:0]      rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               busy_q, busy_d, done_q, done_d;

    logic [CW-1:0]      inflight;
    logic [OW-1:0]      occ;
    logic               push, pop, issue, head_last;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(G_FDEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign ram_we    = 1'b0;
    assign ram_addr  = cur_addr_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign out_vld   = (cnt_q != '0);
    assign out_dat   = fifo_dat_q[rd_ptr_q];
    assign head_last = fifo_last_q[rd_ptr_q];
    assign out_last  = out_vld & head_last;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < G_RDLAT; i++) begin
            inflight = inflight + CW'(vld_sr_q[i]);
        end
        push = vld_sr_q[G_RDLAT-1];
        pop  = out_vld & out_rdy;
        // A word leaving the FIFO this cycle frees its slot for a read issued now,
        // which keeps one word per cycle flowing with the minimum FIFO depth.
        occ   = OW'(inflight) + OW'(cnt_q);
        issue = (state_q == S_ISSUE) & ram_clrrdy & (occ < OW'(G_FDEPTH) + OW'(pop));

        vld_sr_d     = vld_sr_q;
        last_sr_d    = last_sr_q;
        vld_sr_d[0]  = issue;
        last_sr_d[0] = issue & (remain_q == (G_ADDR+1)'(1));
        for (int i = 1; i < G_RDLAT; i++) begin
            vld_sr_d[i]  = vld_sr_q[i-1];
            last_sr_d[i] = last_sr_q[i-1];
        end

        fifo_dat_d  = fifo_dat_q;
        fifo_last_d = fifo_last_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        if (push) begin
            fifo_dat_d[wr_ptr_q]  = ram_dout;
            fifo_last_d[wr_ptr_q] = last_sr_q[G_RDLAT-1];
            wr_ptr_d              = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        cnt_d = cnt_q;
        if (push && !pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!push && pop) begin
            cnt_d = cnt_q - 1'b1;
        end

        state_d    = state_q;
        cur_addr_d = cur_addr_q;
        remain_d   = remain_q;
        done_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        cur_addr_d = base;
                        remain_d   = len;
                        state_d    = ram_clrrdy ? S_ISSUE : S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (ram_clrrdy) begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (issue) begin
                    cur_addr_d = cur_addr_q + 1'b1;
                    remain_d   = remain_q - 1'b1;
                    if (remain_q == (G_ADDR+1)'(1)) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            default: begin
                // The last-flagged word is always the final one returned, so its
                // acceptance implies nothing is left in flight or in the FIFO.
                if (pop && head_last) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cur_addr_q <= '0;
            remain_q   <= '0;
            vld_sr_q   <= '0;
            last_sr_q  <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            for (int i = 0; i < G_FDEPTH; i++) begin
                fifo_dat_q[i]  <= '0;
                fifo_last_q[i] <= 1'b0;
            end
        end else begin
            state_q     <= state_d;
            cur_addr_q  <= cur_addr_d;
            remain_q    <= remain_d;
            vld_sr_q    <= vld_sr_d;
            last_sr_q   <= last_sr_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            fifo_dat_q  <= fifo_dat_d;
            fifo_last_q <= fifo_last_d;
        end
    end
endmodule
